// File: rtl/stream_fifo_flushable_pkg.sv
// Shared helpers for the flushable stream FIFO: index width of a storage array.
package stream_fifo_flushable_pkg;

  // A single entry still needs a one-bit index.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/stream_fifo_flushable.sv
// Valid/ready FIFO, registered outputs, one-cycle minimum latency, no fall-through.
// ready_o only from full flag; flush_i/clr_i empty it in one cycle (clr_i also zeroes storage).
module stream_fifo_flushable
  import stream_fifo_flushable_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter type T = logic,
  localparam int unsigned AddrW = idx_width(Depth)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr_i,
  input  logic           flush_i,
  input  logic           valid_i,
  output logic           ready_o,
  input  T               data_i,
  output logic           valid_o,
  input  logic           ready_i,
  output T               data_o,
  output logic [AddrW:0] usage_o
);

  if (Depth == 0) begin : g_depth_check
    $fatal(1, "stream_fifo_flushable: Depth must be at least 1");
  end

  logic [AddrW-1:0] r_rd_ptr;
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW:0]   r_count;
  T                 r_mem [Depth];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  function automatic logic [AddrW-1:0] next_ptr(input logic [AddrW-1:0] ptr);
    return (ptr == AddrW'(Depth - 1)) ? '0 : ptr + AddrW'(1);
  endfunction

  assign w_full  = (r_count == (AddrW + 1)'(Depth));
  assign w_empty = (r_count == '0);
  // A pop at full does not open ready_o this cycle: ready is a flop decode only.
  assign w_push  = valid_i && !w_full && !flush_i && !clr_i;
  assign w_pop   = !w_empty && ready_i && !flush_i && !clr_i;

  assign ready_o = !w_full;
  assign valid_o = !w_empty;
  assign usage_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (clr_i || flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AddrW + 1)'(1);
        2'b01:   r_count <= r_count - (AddrW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Flushing while upstream presents a word silently drops that word.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(flush_i && valid_i))
    else $warning("stream_fifo_flushable: flush_i with valid_i drops data");

endmodule

// File: tb/tb_stream_fifo_flushable.sv
// Directed bench: Depth=4 fill/drain/full/flush/clear, Depth=3 wrap, Depth=1 alternation.
module tb_stream_fifo_flushable;

  typedef logic [7:0] byte_t;

  logic clk;
  logic rst_n;

  logic  a_clr, a_flush, a_vi, a_ro, a_vo, a_ri;
  byte_t a_di, a_do;
  logic [2:0] a_use;

  logic  b_clr, b_flush, b_vi, b_ro, b_vo, b_ri;
  byte_t b_di, b_do;
  logic [2:0] b_use;

  logic  c_clr, c_flush, c_vi, c_ro, c_vo, c_ri;
  byte_t c_di, c_do;
  logic [1:0] c_use;

  int n_checks = 0;
  int n_pass   = 0;

  stream_fifo_flushable #(.Depth(4), .T(byte_t)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(a_clr), .flush_i(a_flush),
    .valid_i(a_vi), .ready_o(a_ro), .data_i(a_di),
    .valid_o(a_vo), .ready_i(a_ri), .data_o(a_do), .usage_o(a_use)
  );

  stream_fifo_flushable #(.Depth(3), .T(byte_t)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(b_clr), .flush_i(b_flush),
    .valid_i(b_vi), .ready_o(b_ro), .data_i(b_di),
    .valid_o(b_vo), .ready_i(b_ri), .data_o(b_do), .usage_o(b_use)
  );

  stream_fifo_flushable #(.Depth(1), .T(byte_t)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(c_clr), .flush_i(c_flush),
    .valid_i(c_vi), .ready_o(c_ro), .data_i(c_di),
    .valid_o(c_vo), .ready_i(c_ri), .data_o(c_do), .usage_o(c_use)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {a_clr, a_flush, a_vi, a_ri, a_di} = '0;
    {b_clr, b_flush, b_vi, b_ri, b_di} = '0;
    {c_clr, c_flush, c_vi, c_ri, c_di} = '0;
    #22;
    rst_n = 1'b1;
    #2;

    check("rst_valid", 32'(a_vo), 32'd0);
    check("rst_ready", 32'(a_ro), 32'd1);
    check("rst_usage", 32'(a_use), 32'd0);
    check("rst_data",  32'(a_do), 32'd0);

    // Fill Depth=4 with ready_i low
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a_vi = 1'b1; a_di = byte_t'(8'hA1 + i);
      step();
      check("fill_usage", 32'(a_use), 32'(i + 1));
    end
    a_vi = 1'b0;
    check("fill_ready", 32'(a_ro), 32'd0);
    check("fill_head",  32'(a_do), 32'hA1);

    a_ri = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(a_vo), 32'd1);
      check("drain_data",  32'(a_do), 32'(8'hA1 + i));
      step();
    end
    check("drain_empty", 32'(a_vo), 32'd0);
    check("drain_usage", 32'(a_use), 32'd0);
    a_ri = 1'b0;

    // Full with simultaneous pop: pop only, push lands one cycle later
    for (int i = 0; i < 4; i++) begin
      a_vi = 1'b1; a_di = byte_t'(8'hB1 + i);
      step();
    end
    a_di = 8'hC5; a_ri = 1'b1;
    check("full_ready_pre", 32'(a_ro), 32'd0);
    step();
    check("full_pop_usage", 32'(a_use), 32'd3);
    check("full_pop_ready", 32'(a_ro), 32'd1);
    check("full_pop_head",  32'(a_do), 32'hB2);
    a_ri = 1'b0;
    step();
    a_vi = 1'b0;
    check("full_push_usage", 32'(a_use), 32'd4);
    a_ri = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("full_drain", 32'(a_do), (i < 3) ? 32'(8'hB2 + i) : 32'hC5);
      step();
    end
    check("full_drain_empty", 32'(a_vo), 32'd0);
    a_ri = 1'b0;

    // Wrap on Depth=3 at full rate
    b_ri = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b_vi = 1'b1; b_di = byte_t'(8'h30 + i);
      step();
      check("wrap_data",  32'(b_do), 32'(8'h30 + i));
      check("wrap_usage", 32'(b_use), 32'd1);
    end
    b_vi = 1'b0;
    step();
    check("wrap_end_valid", 32'(b_vo), 32'd0);

    // Flush at usage 3; storage keeps C5 in entry 0
    for (int i = 0; i < 3; i++) begin
      a_vi = 1'b1; a_di = byte_t'(8'hD1 + i);
      step();
    end
    a_vi = 1'b0;
    check("pre_flush_usage", 32'(a_use), 32'd3);
    a_flush = 1'b1; a_ri = 1'b1;
    step();
    a_flush = 1'b0; a_ri = 1'b0;
    check("flush_valid", 32'(a_vo), 32'd0);
    check("flush_usage", 32'(a_use), 32'd0);
    check("flush_ready", 32'(a_ro), 32'd1);
    check("flush_keeps_mem", 32'(a_do), 32'hC5);
    a_vi = 1'b1; a_di = 8'h55;
    step();
    a_vi = 1'b0;
    check("post_flush_valid", 32'(a_vo), 32'd1);
    check("post_flush_data",  32'(a_do), 32'h55);
    check("post_flush_usage", 32'(a_use), 32'd1);
    a_ri = 1'b1;
    step();
    a_ri = 1'b0;
    check("post_flush_alone", 32'(a_vo), 32'd0);

    // Clear at usage 2 zeroes storage (entry 0 held 0x55)
    for (int i = 0; i < 2; i++) begin
      a_vi = 1'b1; a_di = byte_t'(8'hE1 + i);
      step();
    end
    a_vi = 1'b0;
    check("pre_clr_usage", 32'(a_use), 32'd2);
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    check("clr_usage", 32'(a_use), 32'd0);
    check("clr_data",  32'(a_do), 32'd0);
    check("clr_ready", 32'(a_ro), 32'd1);

    // Depth=1: valid every other cycle under continuous offer
    c_ri = 1'b1; c_vi = 1'b1;
    for (int j = 0; j < 6; j++) begin
      c_di = byte_t'(8'h70 + j / 2);
      step();
      check("d1_valid", 32'(c_vo), (j % 2 == 0) ? 32'd1 : 32'd0);
      check("d1_ready", 32'(c_ro), (j % 2 == 0) ? 32'd0 : 32'd1);
      if (j % 2 == 0) check("d1_data", 32'(c_do), 32'(8'h70 + j / 2));
    end
    c_vi = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
